// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the micro-sequencer: sequencing codes, control-word field
// positions, FSM state encodings, opcode names and the dispatch result type.
package useq_pkg;

    localparam int DEF_AW  = 5;
    localparam int DEF_CW  = 36;
    localparam int DEF_OPW = 4;

    localparam logic [DEF_AW-1:0] FETCH_ADR = 5'd0;
    localparam logic [DEF_AW-1:0] ERR_ADR   = 5'd31;

    localparam int SEQ_HI  = 35;
    localparam int SEQ_LO  = 34;
    localparam int NEXT_HI = 4;
    localparam int NEXT_LO = 0;

    localparam logic [1:0] SEQ_NEXT     = 2'b00;
    localparam logic [1:0] SEQ_DISPATCH = 2'b01;
    localparam logic [1:0] SEQ_BRNZ     = 2'b10;
    localparam logic [1:0] SEQ_HALT     = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [DEF_OPW-1:0] OP_LOAD  = 4'h1;
    localparam logic [DEF_OPW-1:0] OP_STORE = 4'h2;
    localparam logic [DEF_OPW-1:0] OP_MUL   = 4'h3;
    localparam logic [DEF_OPW-1:0] OP_JMPNZ = 4'h4;
    localparam logic [DEF_OPW-1:0] OP_ADD   = 4'h5;
    localparam logic [DEF_OPW-1:0] OP_SUB   = 4'h6;

    typedef struct packed {
        logic              valid;
        logic [DEF_AW-1:0] adr;
    } disp_t;

endpackage

// File: rtl/micro_sequencer_if.sv
// Control-store / instruction-side bus of the micro-sequencer.
interface micro_sequencer_if
    import useq_pkg::*;
#(
    parameter int AW  = DEF_AW,
    parameter int CW  = DEF_CW,
    parameter int OPW = DEF_OPW
);
    logic           start;
    logic           stall;
    logic [CW-1:0]  ctrl_word;
    logic [OPW-1:0] opcode;
    logic           z_flag;
    logic [AW-1:0]  uaddr;
    logic           ctrl_valid;
    logic           halted;
    logic           illegal_op;

    modport master (
        input  start, stall, ctrl_word, opcode, z_flag,
        output uaddr, ctrl_valid, halted, illegal_op
    );

    modport slave (
        output start, stall, ctrl_word, opcode, z_flag,
        input  uaddr, ctrl_valid, halted, illegal_op
    );
endinterface

// File: rtl/micro_sequencer_dispatch.sv
// Opcode to micro-routine start address table; opcodes not listed are reported invalid.
module opcode_dispatch
    import useq_pkg::*;
#(
    parameter int OPW = DEF_OPW
) (
    input  logic [OPW-1:0] opcode,
    output disp_t          disp
);

    always_comb begin
        disp = '0;
        case (opcode)
            OP_LOAD:  disp = '{valid: 1'b1, adr: 5'd19};
            OP_STORE: disp = '{valid: 1'b1, adr: 5'd21};
            OP_MUL:   disp = '{valid: 1'b1, adr: 5'd18};
            OP_JMPNZ: disp = '{valid: 1'b1, adr: 5'd9};
            OP_ADD:   disp = '{valid: 1'b1, adr: 5'd12};
            OP_SUB:   disp = '{valid: 1'b1, adr: 5'd14};
            default:  disp = '0;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-program counter and IDLE/RUN/HALT sequencing FSM driving the control-store ROM.
module micro_sequencer
    import useq_pkg::*;
#(
    parameter int AW  = DEF_AW,
    parameter int CW  = DEF_CW,
    parameter int OPW = DEF_OPW
) (
    input  logic              clk,
    input  logic              rstn,
    micro_sequencer_if.master bus
);

    logic [AW-1:0] uaddr_p1, uaddr_nxt;
    logic [1:0]    state_p1, state_nxt;
    logic          illegal_p1, illegal_nxt;
    logic [1:0]    seq;
    logic [AW-1:0] next_fld;
    disp_t         disp;
    logic          unused_fields;

    assign seq           = bus.ctrl_word[SEQ_HI:SEQ_LO];
    assign next_fld      = bus.ctrl_word[AW-1:0];
    assign unused_fields = ^bus.ctrl_word[CW-3:AW];

    opcode_dispatch #(.OPW(OPW)) u_dispatch (
        .opcode (bus.opcode),
        .disp   (disp)
    );

    always_comb begin
        uaddr_nxt   = uaddr_p1;
        state_nxt   = state_p1;
        illegal_nxt = illegal_p1;
        case (state_p1)
            ST_IDLE, ST_HALT: begin
                if (bus.start) begin
                    state_nxt = ST_RUN;
                    uaddr_nxt = AW'(FETCH_ADR);
                end
            end
            ST_RUN: begin
                // stall freezes everything regardless of the sequencing code
                if (!bus.stall) begin
                    case (seq)
                        SEQ_NEXT: uaddr_nxt = next_fld;
                        SEQ_DISPATCH: begin
                            if (disp.valid) begin
                                uaddr_nxt = AW'(disp.adr);
                            end else begin
                                uaddr_nxt   = AW'(ERR_ADR);
                                illegal_nxt = 1'b1;
                                state_nxt   = ST_HALT;
                            end
                        end
                        SEQ_BRNZ: uaddr_nxt = bus.z_flag ? uaddr_p1 + 1'b1 : next_fld;
                        default:  state_nxt = ST_HALT;
                    endcase
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---- stage p1: registered micro-address, state and sticky trap flag ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            uaddr_p1   <= AW'(FETCH_ADR);
            state_p1   <= ST_IDLE;
            illegal_p1 <= 1'b0;
        end else begin
            uaddr_p1   <= uaddr_nxt;
            state_p1   <= state_nxt;
            illegal_p1 <= illegal_nxt;
        end
    end

    assign bus.uaddr      = uaddr_p1;
    assign bus.ctrl_valid = (state_p1 == ST_RUN) && !bus.stall;
    assign bus.halted     = (state_p1 == ST_HALT);
    assign bus.illegal_op = illegal_p1;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed scenarios plus random traffic against a behavioural model.
module tb_micro_sequencer;

    logic clk = 1'b0;
    logic rstn;

    micro_sequencer_if bus ();

    micro_sequencer dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_RUN, M_HALT} mst_t;

    mst_t m_state;
    int   m_ua;
    bit   m_ill;
    int   n_chk  = 0;
    int   n_fail = 0;

    // start addresses of the micro-routines per opcode; -1 marks an unmapped opcode
    int disp_tbl [16] = '{-1, 19, 21, 18, 9, 12, 14, -1, -1, -1, -1, -1, -1, -1, -1, -1};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_ua    = 0;
        m_ill   = 1'b0;
    endtask

    task automatic model_step(input int seq, input int nxt, input int opc, input bit z,
                              input bit st, input bit sr);
        if (m_state == M_IDLE || m_state == M_HALT) begin
            if (sr) begin
                m_state = M_RUN;
                m_ua    = 0;
            end
        end else if (!st) begin
            if (seq == 0) m_ua = nxt;
            else if (seq == 1) begin
                if (disp_tbl[opc] >= 0) m_ua = disp_tbl[opc];
                else begin
                    m_ua    = 31;
                    m_ill   = 1'b1;
                    m_state = M_HALT;
                end
            end else if (seq == 2) m_ua = z ? (m_ua + 1) % 32 : nxt;
            else m_state = M_HALT;
        end
    endtask

    // one clock: drive inputs after the falling edge, check, clock, check again
    task automatic cyc(input int seq, input int nxt, input int opc, input bit z,
                       input bit st, input bit sr);
        logic [28:0] mid;
        mid           = 29'($urandom);
        bus.ctrl_word = {2'(seq), mid, 5'(nxt)};
        bus.opcode    = 4'(opc);
        bus.z_flag    = z;
        bus.stall     = st;
        bus.start     = sr;
        #1;
        chk("ctrl_valid", bus.ctrl_valid, (m_state == M_RUN) && !st);
        @(posedge clk);
        model_step(seq, nxt, opc, z, st, sr);
        @(negedge clk);
        chk("uaddr", bus.uaddr, m_ua);
        chk("halted", bus.halted, m_state == M_HALT);
        chk("illegal_op", bus.illegal_op, m_ill);
    endtask

    // asynchronous reset asserted between edges; outputs must clear before the next edge
    task automatic do_reset();
        #3 rstn = 1'b0;
        #1;
        model_reset();
        chk("rst_uaddr", bus.uaddr, 0);
        chk("rst_valid", bus.ctrl_valid, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_illegal", bus.illegal_op, 0);
        @(negedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        rstn          = 1'b0;
        bus.start     = 1'b0;
        bus.stall     = 1'b0;
        bus.ctrl_word = '0;
        bus.opcode    = '0;
        bus.z_flag    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("por_uaddr", bus.uaddr, 0);
        chk("por_valid", bus.ctrl_valid, 0);
        chk("por_halted", bus.halted, 0);
        #1 rstn = 1'b1;

        // fetch then dispatch MUL: 0, 1, 18
        cyc(0, 5, 0, 0, 0, 1);
        chk("t2_ua0", bus.uaddr, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("t2_ua1", bus.uaddr, 1);
        cyc(1, 0, 3, 0, 0, 0);
        chk("t2_mul", bus.uaddr, 18);

        // branch on Z, including wrap from 31
        cyc(0, 9, 0, 0, 0, 0);
        cyc(2, 10, 0, 0, 0, 0);
        chk("t3_brz0", bus.uaddr, 10);
        cyc(0, 9, 0, 0, 0, 0);
        cyc(2, 10, 0, 1, 0, 0);
        chk("t3_brz1", bus.uaddr, 10);
        cyc(0, 31, 0, 0, 0, 0);
        cyc(2, 5, 0, 1, 0, 0);
        chk("t3_wrap", bus.uaddr, 0);

        // three stalled cycles hold uaddr at 20, then a single advance
        cyc(0, 20, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(3, 7, 15, 1, 1, 1);
            chk("t4_hold", bus.uaddr, 20);
        end
        cyc(0, 7, 0, 0, 0, 0);
        chk("t4_adv", bus.uaddr, 7);

        // reset mid-run at uaddr 12
        cyc(0, 12, 0, 0, 0, 0);
        chk("t1_ua12", bus.uaddr, 12);
        do_reset();

        // illegal opcode traps to 31 and halts; restart keeps the sticky flag
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 3, 15, 0, 0, 0);
        chk("t5_trap", bus.uaddr, 31);
        chk("t5_ill", bus.illegal_op, 1);
        chk("t5_halt", bus.halted, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t5_restart", bus.uaddr, 0);
        chk("t5_sticky", bus.illegal_op, 1);
        chk("t5_run", bus.halted, 0);

        // HALT code parks the sequencer; non-start inputs have no effect
        cyc(0, 23, 0, 0, 0, 0);
        cyc(3, 4, 0, 0, 0, 0);
        chk("t6_ua", bus.uaddr, 23);
        chk("t6_halt", bus.halted, 1);
        for (int i = 0; i < 4; i++) begin
            cyc($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 15),
                1'($urandom), 1'($urandom), 1'b0);
            chk("t6_park", bus.uaddr, 23);
        end

        // random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 15),
                1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
            if (i == 300) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
